// File: rtl/emu_ctrl_pkg.sv
// Shared types and helpers for the emulation control block.
package emu_ctrl_pkg;

   // Widest emu_time the saturating adder supports.
   localparam int unsigned MaxTimeBits = 64;

   typedef enum logic [1:0] {
      ModeFree   = 2'd0,
      ModeStopAt = 2'd1,
      ModeStep   = 2'd2
   } emu_mode_t;

   typedef enum logic [1:0] {
      StHalt = 2'd0,
      StRun  = 2'd1,
      StStep = 2'd2
   } emu_state_t;

   // a + b clamped to the largest value representable in 'width' bits.
   function automatic logic [MaxTimeBits-1:0] sat_add(
      input logic [MaxTimeBits-1:0] a,
      input logic [MaxTimeBits-1:0] b,
      input int unsigned            width
   );
      logic [MaxTimeBits:0]   sum;
      logic [MaxTimeBits-1:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (width >= MaxTimeBits) ? '1 : ((64'd1 << width) - 64'd1);
      if (sum[MaxTimeBits] || (sum[MaxTimeBits-1:0] > lim)) begin
         return lim;
      end
      return sum[MaxTimeBits-1:0];
   endfunction

endpackage

// File: rtl/emu_ctrl_mc_dec_chan.sv
// One decimation channel: counts advances and pulses a strobe on threshold.
module dec_chan #(
   parameter int unsigned DEC_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_adv,
   input  logic [DEC_BITS-1:0] i_thr,
   output logic                o_strobe
);

   logic [DEC_BITS-1:0] r_cnt;
   logic                r_strobe;

   // Count advances; >= (not ==) lets a lowered threshold restart the channel at once.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_strobe <= 1'b0;
      end else if (i_adv) begin
         if (r_cnt >= i_thr) begin
            r_cnt    <= '0;
            r_strobe <= 1'b1;
         end else begin
            r_cnt    <= r_cnt + DEC_BITS'(1);
            r_strobe <= 1'b0;
         end
      end else begin
         r_strobe <= 1'b0;
      end
   end

   assign o_strobe = r_strobe;

endmodule

// File: rtl/emu_ctrl_mc.sv
// Emulation run control: HALT/RUN/STEP FSM, saturating time counter and
// N_CH independent decimation channels.
module emu_ctrl_mc
   import emu_ctrl_pkg::*;
#(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned DEC_BITS  = 8,
   parameter int unsigned TIME_BITS = 32,
   parameter int unsigned DT_BITS   = 16
) (
   input  logic                     emu_clk,
   input  logic                     emu_rst,
   input  logic [N_CH*DEC_BITS-1:0] emu_dec_thr,
   input  logic [1:0]               emu_mode,
   input  logic [TIME_BITS-1:0]     emu_stop_time,
   input  logic [DT_BITS-1:0]       emu_dt,
   input  logic                     step_req,
   output logic [TIME_BITS-1:0]     emu_time,
   output logic                     emu_stall,
   output logic [N_CH-1:0]          dec_strobe,
   output logic                     emu_halted
);

   emu_state_t             r_state;
   emu_state_t             w_state_next;
   logic [TIME_BITS-1:0]   r_time;
   logic [MaxTimeBits-1:0] w_sum_wide;
   logic                   w_stop_hit;
   logic                   w_adv;

   assign w_adv      = (r_state == StRun) || (r_state == StStep);
   assign w_sum_wide = sat_add(MaxTimeBits'(r_time), MaxTimeBits'(emu_dt), TIME_BITS);
   // Saturation never crosses a representable stop time, so the clamped sum is safe here.
   assign w_stop_hit = (w_sum_wide >= MaxTimeBits'(emu_stop_time));

   // State register.
   always_ff @(posedge emu_clk) begin
      if (!emu_rst) begin
         r_state <= StHalt;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode; mode 3 behaves as STEP via the default arms.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StHalt: begin
            case (emu_mode)
               ModeFree:   w_state_next = StRun;
               ModeStopAt: if (r_time < emu_stop_time) w_state_next = StRun;
               default:    if (step_req) w_state_next = StStep;
            endcase
         end
         StRun: begin
            case (emu_mode)
               ModeFree:   w_state_next = StRun;
               ModeStopAt: if (w_stop_hit) w_state_next = StHalt;
               default:    w_state_next = StHalt;
            endcase
         end
         StStep:  w_state_next = StHalt;
         default: w_state_next = StHalt;
      endcase
   end

   // Emulation time advances on every advancing cycle, clamped at all-ones.
   always_ff @(posedge emu_clk) begin
      if (!emu_rst) begin
         r_time <= '0;
      end else if (w_adv) begin
         r_time <= w_sum_wide[TIME_BITS-1:0];
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      dec_chan #(
         .DEC_BITS(DEC_BITS)
      ) u_dec_chan (
         .i_clk   (emu_clk),
         .i_rst_n (emu_rst),
         .i_adv   (w_adv),
         .i_thr   (emu_dec_thr[g*DEC_BITS +: DEC_BITS]),
         .o_strobe(dec_strobe[g])
      );
   end

   assign emu_time   = r_time;
   assign emu_stall  = ~w_adv;
   assign emu_halted = (r_state == StHalt);

endmodule

// File: tb/tb_emu_ctrl_mc.sv
// Directed bench for emu_ctrl_mc with a queue-based scoreboard.
module tb_emu_ctrl_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (default parameters).
   logic        rst;
   logic [31:0] thr;
   logic [1:0]  mode;
   logic [31:0] stop_t;
   logic [15:0] dt;
   logic        step_req;
   logic [31:0] time_o;
   logic        stall_o;
   logic [3:0]  strb_o;
   logic        halted_o;

   // Narrow-time DUT for saturation.
   logic        rst8;
   logic [7:0]  thr8;
   logic [1:0]  mode8;
   logic [7:0]  stop8;
   logic [15:0] dt8;
   logic        step8;
   logic [7:0]  time8;
   logic        stall8;
   logic [0:0]  strb8;
   logic        halted8;

   emu_ctrl_mc dut (
      .emu_clk      (clk),
      .emu_rst      (rst),
      .emu_dec_thr  (thr),
      .emu_mode     (mode),
      .emu_stop_time(stop_t),
      .emu_dt       (dt),
      .step_req     (step_req),
      .emu_time     (time_o),
      .emu_stall    (stall_o),
      .dec_strobe   (strb_o),
      .emu_halted   (halted_o)
   );

   emu_ctrl_mc #(
      .N_CH     (1),
      .DEC_BITS (8),
      .TIME_BITS(8),
      .DT_BITS  (16)
   ) dut8 (
      .emu_clk      (clk),
      .emu_rst      (rst8),
      .emu_dec_thr  (thr8),
      .emu_mode     (mode8),
      .emu_stop_time(stop8),
      .emu_dt       (dt8),
      .step_req     (step8),
      .emu_time     (time8),
      .emu_stall    (stall8),
      .dec_strobe   (strb8),
      .emu_halted   (halted8)
   );

   typedef struct {
      string       tag;
      bit          sel;
      logic [31:0] t;
      logic [3:0]  s;
      bit          cs;
      logic        stall;
      logic        halt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push the expectation for the coming edge, let it happen, then pop and compare.
   task automatic expect_cycle(input string tag, input bit sel, input logic [31:0] t,
                               input logic [3:0] s, input bit cs, input logic stall,
                               input logic halt);
      exp_t e;
      exp_t p;
      e.tag = tag; e.sel = sel; e.t = t; e.s = s; e.cs = cs; e.stall = stall; e.halt = halt;
      sb.push_back(e);
      tick();
      p = sb.pop_front();
      if (!p.sel) begin
         chk({p.tag, " time"}, time_o, p.t);
         if (p.cs) chk({p.tag, " strobe"}, 32'(strb_o), 32'(p.s));
         chk({p.tag, " stall"}, 32'(stall_o), 32'(p.stall));
         chk({p.tag, " halted"}, 32'(halted_o), 32'(p.halt));
      end else begin
         chk({p.tag, " time8"}, 32'(time8), p.t);
         chk({p.tag, " stall8"}, 32'(stall8), 32'(p.stall));
         chk({p.tag, " halted8"}, 32'(halted8), 32'(p.halt));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] s;
      rst = 1'b0; mode = 2'd0; dt = 16'd1; thr = {8'd7, 8'd3, 8'd1, 8'd0};
      stop_t = 32'd0; step_req = 1'b0;
      rst8 = 1'b0; thr8 = 8'd0; mode8 = 2'd0; stop8 = 8'd0; dt8 = 16'd100; step8 = 1'b0;
      tick();

      // Reset state, then FREE run with thresholds {0,1,3,7}.
      expect_cycle("reset", 0, 32'd0, 4'd0, 1, 1'b1, 1'b1);
      rst = 1'b1;
      expect_cycle("free_entry", 0, 32'd0, 4'd0, 1, 1'b0, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         s[0] = 1'b1;
         s[1] = (k % 2 == 0);
         s[2] = (k % 4 == 0);
         s[3] = (k % 8 == 0);
         expect_cycle("free", 0, 32'(k), s, 1, 1'b0, 1'b0);
      end

      // STOP_AT dt=3 stop=10: 0,3,6,9,12 then halt and hold.
      rst = 1'b0; mode = 2'd1; dt = 16'd3; stop_t = 32'd10;
      expect_cycle("stop_rst", 0, 32'd0, 4'd0, 1, 1'b1, 1'b1);
      rst = 1'b1;
      expect_cycle("stop_t0", 0, 32'd0, 4'd0, 1, 1'b0, 1'b0);
      expect_cycle("stop_t3", 0, 32'd3, 4'd0, 0, 1'b0, 1'b0);
      expect_cycle("stop_t6", 0, 32'd6, 4'd0, 0, 1'b0, 1'b0);
      expect_cycle("stop_t9", 0, 32'd9, 4'd0, 0, 1'b0, 1'b0);
      expect_cycle("stop_t12", 0, 32'd12, 4'd0, 0, 1'b1, 1'b1);
      expect_cycle("stop_hold", 0, 32'd12, 4'd0, 1, 1'b1, 1'b1);
      expect_cycle("stop_hold", 0, 32'd12, 4'd0, 1, 1'b1, 1'b1);

      // STOP_AT with stop time 0 straight after reset: no advances.
      rst = 1'b0; stop_t = 32'd0;
      tick();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) expect_cycle("stop0", 0, 32'd0, 4'd0, 1, 1'b1, 1'b1);

      // STEP mode, dt=5, three pulses; a pulse during STEP must be ignored.
      rst = 1'b0; mode = 2'd2; dt = 16'd5;
      tick();
      rst = 1'b1;
      expect_cycle("step_idle", 0, 32'd0, 4'd0, 1, 1'b1, 1'b1);
      step_req = 1'b1;
      expect_cycle("step1_in", 0, 32'd0, 4'd0, 1, 1'b0, 1'b0);
      expect_cycle("step1_out", 0, 32'd5, 4'b0001, 1, 1'b1, 1'b1);
      step_req = 1'b0;
      for (int k = 0; k < 3; k++) expect_cycle("step1_hold", 0, 32'd5, 4'd0, 1, 1'b1, 1'b1);
      step_req = 1'b1;
      expect_cycle("step2_in", 0, 32'd5, 4'd0, 1, 1'b0, 1'b0);
      step_req = 1'b0;
      expect_cycle("step2_out", 0, 32'd10, 4'b0011, 1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) expect_cycle("step2_hold", 0, 32'd10, 4'd0, 1, 1'b1, 1'b1);
      step_req = 1'b1;
      expect_cycle("step3_in", 0, 32'd10, 4'd0, 1, 1'b0, 1'b0);
      step_req = 1'b0;
      expect_cycle("step3_out", 0, 32'd15, 4'b0001, 1, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) expect_cycle("step3_hold", 0, 32'd15, 4'd0, 1, 1'b1, 1'b1);

      // Reset mid-RUN together with step_req.
      mode = 2'd0; dt = 16'd1;
      expect_cycle("mr_run", 0, 32'd15, 4'd0, 0, 1'b0, 1'b0);
      expect_cycle("mr_adv", 0, 32'd16, 4'd0, 0, 1'b0, 1'b0);
      expect_cycle("mr_adv", 0, 32'd17, 4'd0, 0, 1'b0, 1'b0);
      rst = 1'b0; step_req = 1'b1;
      expect_cycle("mr_rst", 0, 32'd0, 4'd0, 1, 1'b1, 1'b1);
      rst = 1'b1; step_req = 1'b0; mode = 2'd2;
      expect_cycle("mr_after", 0, 32'd0, 4'd0, 1, 1'b1, 1'b1);

      // Threshold 7 -> 2 on channel 3 while its count is 5.
      rst = 1'b0; mode = 2'd0;
      tick();
      rst = 1'b1;
      expect_cycle("thr_entry", 0, 32'd0, 4'd0, 1, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++) expect_cycle("thr_pre", 0, 32'(k), 4'd0, 0, 1'b0, 1'b0);
      thr[31:24] = 8'd2;
      for (int k = 6; k <= 12; k++) begin
         s[0] = 1'b1;
         s[1] = (k % 2 == 0);
         s[2] = (k % 4 == 0);
         s[3] = ((k - 6) % 3 == 0);
         expect_cycle("thr_post", 0, 32'(k), s, 1, 1'b0, 1'b0);
      end

      // Saturation on the 8-bit time instance: 0,100,200,255,255.
      rst8 = 1'b1;
      expect_cycle("sat_t0", 1, 32'd0, 4'd0, 0, 1'b0, 1'b0);
      expect_cycle("sat_t100", 1, 32'd100, 4'd0, 0, 1'b0, 1'b0);
      expect_cycle("sat_t200", 1, 32'd200, 4'd0, 0, 1'b0, 1'b0);
      expect_cycle("sat_t255", 1, 32'd255, 4'd0, 0, 1'b0, 1'b0);
      expect_cycle("sat_hold", 1, 32'd255, 4'd0, 0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
